// File: rtl/dmi_initiator.sv
// DMI requester: turns single-shot host commands into one DMI request/response
// transaction at a time, with dtmcs-style sticky status and a response timeout.
module dmi_initiator #(
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   input  logic [1:0]  cmd_op_i,
   input  logic [6:0]  cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   input  logic        dmireset_i,
   input  logic        dmihardreset_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  status_o,
   output logic [31:0] rdata_o,
   output logic        dmi_rst_no,
   output logic        dmi_req_valid_o,
   input  logic        dmi_req_ready_i,
   output logic [40:0] dmi_req_o,
   input  logic        dmi_resp_valid_i,
   output logic        dmi_resp_ready_o,
   input  logic [33:0] dmi_resp_i
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   state_e              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [1:0]          status_q, status_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                dmi_rst_n_q, dmi_rst_n_d;
   logic                req_valid_q, req_valid_d;
   logic                resp_ready_q, resp_ready_d;
   logic [40:0]         req_q, req_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic cmd_rw, req_hs, resp_hs, expire;

   always_comb begin
      cmd_rw  = cmd_valid_i && (cmd_op_i == 2'd1 || cmd_op_i == 2'd2);
      req_hs  = (state_q == REQ) && req_valid_q && dmi_req_ready_i;
      resp_hs = (state_q == RESP) && resp_ready_q && dmi_resp_valid_i;
      // A response on the expiry edge completes normally.
      expire  = (state_q != IDLE) && (cnt_q == CntLast) && !resp_hs;

      // NOTE: every _d gets a default here so no path through the case infers a latch.
      state_d      = state_q;
      done_d       = 1'b0;
      status_d     = status_q;
      rdata_d      = rdata_q;
      dmi_rst_n_d  = 1'b1;
      req_valid_d  = req_valid_q;
      resp_ready_d = resp_ready_q;
      req_d        = req_q;
      cnt_d        = cnt_q;

      if (dmihardreset_i) begin
         state_d      = IDLE;
         req_valid_d  = 1'b0;
         resp_ready_d = 1'b0;
         dmi_rst_n_d  = 1'b0;
         status_d     = 2'd0;
         cnt_d        = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_rw && (status_q == 2'd0 || dmireset_i)) begin
                  state_d     = REQ;
                  req_valid_d = 1'b1;
                  req_d       = {cmd_addr_i, cmd_op_i, cmd_data_i};
                  cnt_d       = '0;
               end
            end
            REQ, RESP: begin
               cnt_d = cnt_q + 1'b1;
               if (cmd_rw && status_q == 2'd0) status_d = 2'd3;
               if (resp_hs) begin
                  rdata_d      = dmi_resp_i[33:2];
                  if (dmi_resp_i[1:0] != 2'd0)
                     status_d = (dmi_resp_i[1:0] == 2'd1) ? 2'd2 : dmi_resp_i[1:0];
                  state_d      = IDLE;
                  resp_ready_d = 1'b0;
                  done_d       = 1'b1;
               end else if (expire) begin
                  status_d     = 2'd2;
                  done_d       = 1'b1;
                  state_d      = IDLE;
                  req_valid_d  = 1'b0;
                  resp_ready_d = 1'b0;
                  dmi_rst_n_d  = 1'b0;
               end else if (req_hs) begin
                  state_d      = RESP;
                  req_valid_d  = 1'b0;
                  resp_ready_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         if (dmireset_i) status_d = 2'd0;
      end

      busy_d = (state_d != IDLE);
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         status_q     <= 2'd0;
         rdata_q      <= '0;
         dmi_rst_n_q  <= 1'b1;
         req_valid_q  <= 1'b0;
         resp_ready_q <= 1'b0;
         req_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         status_q     <= status_d;
         rdata_q      <= rdata_d;
         dmi_rst_n_q  <= dmi_rst_n_d;
         req_valid_q  <= req_valid_d;
         resp_ready_q <= resp_ready_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign status_o         = status_q;
   assign rdata_o          = rdata_q;
   assign dmi_rst_no       = dmi_rst_n_q;
   assign dmi_req_valid_o  = req_valid_q;
   assign dmi_resp_ready_o = resp_ready_q;
   assign dmi_req_o        = req_q;

endmodule
